// File: rtl/syscall_unit.sv
// MIPS syscall service unit: print_int (1), read_int (5), exit (10); stalls the datapath while busy.
// Optional read_int support is built only when SYSCALL_READ_INT_EN is defined.
module syscall_unit #(
    parameter int TX_NEWLINE = 1,
    parameter int WB_REG     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        syscall,
    input  logic [31:0] v0_in,
    input  logic [31:0] a0_in,
    output logic        stall,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        halted,
    output logic        bad_code
);

    typedef enum logic [2:0] {
        IDLE, PR_SIGN, PR_DIG, PR_EMIT, PR_NL, HALT
`ifdef SYSCALL_READ_INT_EN
        , RD, WB
`endif
    } state_t;

    state_t      state;
    logic        syscall_q;
    logic        syscall_rise;
    logic [31:0] mag;
    logic [3:0]  idx;
    logic [3:0]  dig;
    logic        started;

`ifdef SYSCALL_READ_INT_EN
    logic [31:0] acc;
    logic        neg;
    logic        first;
`else
    logic        unused_rx;
    assign unused_rx = ^{rx_valid, rx_data};
    assign rx_ready  = 1'b0;
    assign wb_en     = 1'b0;
    assign wb_data   = 32'h0;
`endif

    assign syscall_rise = syscall & ~syscall_q;
    assign stall        = syscall_rise | (state != IDLE);
    assign wb_reg       = 5'(WB_REG);

    function automatic logic [31:0] pow10(input logic [3:0] i);
        case (i)
            4'd9:    pow10 = 32'd1000000000;
            4'd8:    pow10 = 32'd100000000;
            4'd7:    pow10 = 32'd10000000;
            4'd6:    pow10 = 32'd1000000;
            4'd5:    pow10 = 32'd100000;
            4'd4:    pow10 = 32'd10000;
            4'd3:    pow10 = 32'd1000;
            4'd2:    pow10 = 32'd100;
            4'd1:    pow10 = 32'd10;
            default: pow10 = 32'd1;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            syscall_q <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h0;
            halted    <= 1'b0;
            bad_code  <= 1'b0;
            mag       <= 32'h0;
            idx       <= 4'd0;
            dig       <= 4'd0;
            started   <= 1'b0;
`ifdef SYSCALL_READ_INT_EN
            rx_ready  <= 1'b0;
            wb_en     <= 1'b0;
            wb_data   <= 32'h0;
            acc       <= 32'h0;
            neg       <= 1'b0;
            first     <= 1'b0;
`endif
        end else begin
            syscall_q <= syscall;
            bad_code  <= 1'b0;
            case (state)
                // Dispatch happens on the latching edge so an unsupported code stalls only one cycle.
                IDLE: if (syscall_rise) begin
                    case (v0_in)
                        32'd1: begin
                            state <= PR_SIGN;
                            if (a0_in[31]) begin
                                mag      <= -a0_in;
                                tx_valid <= 1'b1;
                                tx_data  <= 8'h2D;
                            end else begin
                                mag <= a0_in;
                            end
                        end
`ifdef SYSCALL_READ_INT_EN
                        32'd5: begin
                            state    <= RD;
                            rx_ready <= 1'b1;
                            acc      <= 32'h0;
                            neg      <= 1'b0;
                            first    <= 1'b1;
                        end
`endif
                        32'd10: begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                        default: bad_code <= 1'b1;
                    endcase
                end
                PR_SIGN: if (!tx_valid || tx_ready) begin
                    tx_valid <= 1'b0;
                    idx      <= 4'd9;
                    dig      <= 4'd0;
                    started  <= 1'b0;
                    state    <= PR_DIG;
                end
                // Repeated subtraction per decimal place; leading zeros are skipped until the first nonzero.
                PR_DIG: begin
                    if (mag >= pow10(idx)) begin
                        mag <= mag - pow10(idx);
                        dig <= dig + 4'd1;
                    end else if (dig != 4'd0 || started || idx == 4'd0) begin
                        tx_valid <= 1'b1;
                        tx_data  <= 8'h30 + {4'h0, dig};
                        started  <= 1'b1;
                        state    <= PR_EMIT;
                    end else begin
                        idx <= idx - 4'd1;
                        dig <= 4'd0;
                    end
                end
                PR_EMIT: if (tx_ready) begin
                    if (idx == 4'd0) begin
                        state <= PR_NL;
                        if (TX_NEWLINE != 0) tx_data <= 8'h0A;
                        else tx_valid <= 1'b0;
                    end else begin
                        tx_valid <= 1'b0;
                        idx      <= idx - 4'd1;
                        dig      <= 4'd0;
                        state    <= PR_DIG;
                    end
                end
                PR_NL: if (!tx_valid || tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
                HALT: state <= HALT;
`ifdef SYSCALL_READ_INT_EN
                // rx_ready is held high throughout RD, so rx_valid alone marks an accepted byte.
                RD: if (rx_valid) begin
                    if (rx_data == 8'h0A) begin
                        rx_ready <= 1'b0;
                        wb_en    <= 1'b1;
                        wb_data  <= neg ? -acc : acc;
                        state    <= WB;
                    end else begin
                        first <= 1'b0;
                        if (rx_data == 8'h2D && first)
                            neg <= 1'b1;
                        else if (rx_data >= 8'h30 && rx_data <= 8'h39)
                            acc <= acc * 32'd10 + {28'h0, rx_data[3:0]};
                    end
                end
                WB: begin
                    wb_en <= 1'b0;
                    state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: tx bytes and write-backs are checked against scoreboard queues.
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        syscall = 1'b0;
    logic [31:0] v0_in = 32'h0;
    logic [31:0] a0_in = 32'h0;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        stall, tx_valid, rx_ready, wb_en, halted, bad_code;
    logic [7:0]  tx_data;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    syscall_unit #(.TX_NEWLINE(1), .WB_REG(2)) dut (
        .clk(clk), .rst_n(rst_n), .syscall(syscall), .v0_in(v0_in), .a0_in(a0_in),
        .stall(stall), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .halted(halted), .bad_code(bad_code)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] wb_q[$];
    int          hs_count = 0;
    int          wb_count = 0;
    int          bad_count = 0;
    int          tx_mode = 0;
    int          cyc = 0;
    logic        prev_wait = 1'b0;
    logic [7:0]  prev_data = 8'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic do_syscall(input logic [31:0] v0, input logic [31:0] a0);
        v0_in = v0;
        a0_in = a0;
        syscall = 1'b1;
        #1;
        check("stall_on_rise", {31'h0, stall}, 32'd1);
        @(posedge clk); #1;
        syscall = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 600 && stall; i++) begin
            @(posedge clk); #1;
        end
        check(tag, {31'h0, stall}, 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50 && !rx_ready; i++) begin
            @(posedge clk); #1;
        end
        check("rx_ready_wait", {31'h0, rx_ready}, 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"},    {31'h0, stall},    32'd0);
        check({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'd0);
        check({tag, "_tx_data"},  {24'h0, tx_data},  32'd0);
        check({tag, "_rx_ready"}, {31'h0, rx_ready}, 32'd0);
        check({tag, "_wb_en"},    {31'h0, wb_en},    32'd0);
        check({tag, "_wb_data"},  wb_data,           32'd0);
        check({tag, "_halted"},   {31'h0, halted},   32'd0);
        check({tag, "_bad_code"}, {31'h0, bad_code}, 32'd0);
        check({tag, "_wb_reg"},   {27'h0, wb_reg},   32'd2);
    endtask

    // tx_ready pacing: always ready, or ready one cycle in three
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            tx_ready = (tx_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wait = 1'b0;
        end else begin
            if (prev_wait) begin
                check("tx_hold_valid", {31'h0, tx_valid}, 32'd1);
                check("tx_hold_data", {24'h0, tx_data}, {24'h0, prev_data});
            end
            if (tx_valid && tx_ready) begin
                hs_count++;
                check("tx_stall_during_print", {31'h0, stall}, 32'd1);
                if (exp_q.size() == 0) check("tx_unexpected_byte", {24'h0, tx_data}, 32'h100);
                else check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end
            if (wb_en) begin
                wb_count++;
                check("wb_reg", {27'h0, wb_reg}, 32'd2);
                if (wb_q.size() == 0) check("wb_unexpected", wb_data, 32'hDEAD_BEEF);
                else check("wb_data", wb_data, wb_q.pop_front());
            end
            if (bad_code) bad_count++;
            prev_wait = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end of the directed sequence");
        $fatal(1, "timeout");
    end

    initial begin
        int h0;
        int b0;
        #2;
        check_reset_outputs("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1234, sink always ready
        tx_mode = 0;
        push_str("1234\n");
        do_syscall(32'd1, 32'd1234);
        wait_idle("print_1234_done");
        check("print_1234_drained", exp_q.size(), 32'd0);

        // -7 with back-pressure, then 0 and INT_MIN
        tx_mode = 1;
        push_str("-7\n");
        do_syscall(32'd1, 32'hFFFF_FFF9);
        wait_idle("print_m7_done");
        check("print_m7_drained", exp_q.size(), 32'd0);
        tx_mode = 0;
        push_str("0\n");
        do_syscall(32'd1, 32'd0);
        wait_idle("print_0_done");
        push_str("-2147483648\n");
        do_syscall(32'd1, 32'h8000_0000);
        wait_idle("print_min_done");
        check("print_min_drained", exp_q.size(), 32'd0);

        // Unsupported code: one-cycle stall, one-cycle bad_code
        b0 = bad_count;
        do_syscall(32'd3, 32'd0);
        check("bad_pulse", {31'h0, bad_code}, 32'd1);
        check("bad_stall_one_cycle", {31'h0, stall}, 32'd0);
        @(posedge clk); #1;
        check("bad_pulse_end", {31'h0, bad_code}, 32'd0);
        check("bad_count_single", bad_count, b0 + 1);

        // Held syscall: only one service
        b0 = bad_count;
        v0_in = 32'd3;
        syscall = 1'b1;
        repeat (5) @(posedge clk);
        #1 syscall = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("held_bad_once", bad_count, b0 + 1);
        push_str("7\n");
        v0_in = 32'd1;
        a0_in = 32'd7;
        syscall = 1'b1;
        repeat (5) @(posedge clk);
        #1 syscall = 1'b0;
        wait_idle("held_print_done");
        repeat (5) @(posedge clk);
        #1 check("held_print_once", exp_q.size(), 32'd0);

        // read_int
        b0 = bad_count;
`ifdef SYSCALL_READ_INT_EN
        wb_q.push_back(32'hFFFF_FFD6);
        do_syscall(32'd5, 32'd0);
        send_rx(8'h2D);
        send_rx(8'h34);
        send_rx(8'h78);
        send_rx(8'h32);
        send_rx(8'h0A);
        wait_idle("read_done");
        check("read_wb_once", wb_count, 32'd1);
        check("read_wb_drained", wb_q.size(), 32'd0);
        check("read_no_bad", bad_count, b0);
`else
        do_syscall(32'd5, 32'd0);
        check("read_disabled_bad", {31'h0, bad_code}, 32'd1);
        repeat (3) @(posedge clk);
        #1 check("read_disabled_no_wb", wb_count, 32'd0);
        check("read_disabled_rx_ready", {31'h0, rx_ready}, 32'd0);
`endif

        // exit: sticky halt, later syscalls ignored
        h0 = hs_count;
        do_syscall(32'd10, 32'd0);
        check("halt_set", {31'h0, halted}, 32'd1);
        repeat (5) @(posedge clk);
        #1 check("halt_sticky", {31'h0, halted}, 32'd1);
        check("halt_stall", {31'h0, stall}, 32'd1);
        do_syscall(32'd1, 32'd42);
        repeat (30) @(posedge clk);
        #1 check("halt_no_tx", hs_count, h0);
        check("halt_still", {31'h0, halted}, 32'd1);
        rst_n = 1'b0;
        #1 check("halt_cleared", {31'h0, halted}, 32'd0);
        check("halt_reset_stall", {31'h0, stall}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset mid-print after two bytes
        h0 = hs_count;
        push_str("98");
        do_syscall(32'd1, 32'd98765);
        for (int i = 0; i < 200 && hs_count < h0 + 2; i++) begin
            @(negedge clk); #1;
        end
        check("midreset_two_bytes", hs_count, h0 + 2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        check("midreset_drained", exp_q.size(), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        push_str("5\n");
        do_syscall(32'd1, 32'd5);
        wait_idle("post_reset_print_done");
        check("post_reset_drained", exp_q.size(), 32'd0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
